// File: rtl/cipher_uart_rx.sv
// cipher_uart_rx: 16x-oversampled UART receiver with 3-sample majority voting, optional parity
// and a receive buffer; defining CIPHER_RX_FIFO_EN turns the holding register into a 4-entry FIFO.
module cipher_uart_rx #(
  parameter int CLK_FREQ    = 30_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q;
  logic                   rx_s, tick, vote, push, pop, full, wr_en;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign tick       = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));
  // The third vote is the live tick-9 sample, so a bit resolves on the tick-9 edge itself.
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign busy       = (state_q != IDLE);
  assign pop        = rx_valid & rx_ready;
  assign wr_en      = push & (~full | pop);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      div_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= push & full & ~pop;
    end
  end

  // The tick count runs on through START into DATA; bit_q == 0 marks the tail of the start
  // bit, whose tick-9 event is skipped so every later bit is voted at its own centre.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;

    if (state_q == IDLE) begin
      div_d  = '0;
      tick_d = '0;
    end else if (tick) begin
      div_d  = '0;
      tick_d = tick_q + 4'd1;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end

    if (tick && tick_q == 4'd6) smp_d[0] = rx_s;
    if (tick && tick_q == 4'd7) smp_d[1] = rx_s;

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = START;
          bit_d     = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (tick && tick_q == 4'd7) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && tick_q == 4'd8) begin
          bit_d = bit_q + 4'd1;
          if (bit_q != 4'd0) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS)) state_d = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (tick && tick_q == 4'd8) begin
          par_bad_d = (PARITY == 2) ? (vote == ^shift_q) : (vote != ^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick && tick_q == 4'd8) begin
          state_d = IDLE;
          if (!vote)          ferr_d = 1'b1;
          else if (par_bad_q) perr_d = 1'b1;
          else                push   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CIPHER_RX_FIFO_EN
  logic [DATA_BITS-1:0] mem_q [4];
  logic [1:0]           wr_q, rd_q;
  logic [2:0]           cnt_q;

  assign full     = cnt_q[2];
  assign rx_valid = (cnt_q != 3'd0);
  assign rx_data  = rx_valid ? mem_q[rd_q] : '0;

  // NOTE: storage is not reset; the output gate above hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 2'd1;
      if (pop)   rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, wr_en} - {2'b00, pop};
    end
  end
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_v_q;

  assign full     = hold_v_q;
  assign rx_valid = hold_v_q;
  assign rx_data  = hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      if (wr_en) hold_q <= shift_q;
      hold_v_q <= wr_en | (hold_v_q & ~pop);
    end
  end
`endif

endmodule
